// File: rtl/sync_fifo_prog.sv
// Single-clock FIFO with any depth >= 2, optional first-word-fall-through,
// programmable almost-full/almost-empty thresholds, occupancy count,
// synchronous flush and sticky overflow/underflow flags.
module sync_fifo_prog #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter bit          FWFT       = 1'b0,
    parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] rd_data,
    input  logic [CNT_WIDTH-1:0]  afull_thr,
    input  logic [CNT_WIDTH-1:0]  aempty_thr,
    output logic                  full,
    output logic                  empty,
    output logic                  afull,
    output logic                  aempty,
    output logic [CNT_WIDTH-1:0]  fifo_cnt,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned PTR_WIDTH = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [PTR_WIDTH-1:0] PTR_LAST = PTR_WIDTH'(FIFO_DEPTH - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_FULL = CNT_WIDTH'(FIFO_DEPTH);

    logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
    logic [PTR_WIDTH-1:0]  wr_ptr;
    logic [PTR_WIDTH-1:0]  rd_ptr;
    logic                  wr_vld;
    logic                  rd_vld;

    // Pointers wrap by explicit compare so non-power-of-two depths work.
    function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_WIDTH'(1);
    endfunction

    // Status flags are plain compares of the registered occupancy counter.
    assign full   = (fifo_cnt == CNT_FULL);
    assign empty  = (fifo_cnt == '0);
    assign afull  = (fifo_cnt >= afull_thr);
    assign aempty = (fifo_cnt <= aempty_thr);

    assign wr_vld = wr_en & ~full;
    assign rd_vld = rd_en & ~empty;

    // Pointers, occupancy and sticky error flags; clear wins over traffic.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_cnt  <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (rd_vld) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({wr_vld, rd_vld})
                2'b10:   fifo_cnt <= fifo_cnt + CNT_WIDTH'(1);
                2'b01:   fifo_cnt <= fifo_cnt - CNT_WIDTH'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
            overflow  <= overflow  | (wr_en & full);
            underflow <= underflow | (rd_en & empty);
        end
    end

    // Storage array; contents survive reset and clear, only pointers move.
    always_ff @(posedge clk) begin
        if (!clear && wr_vld) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            // Head entry is presented combinationally; rd_en acknowledges it.
            assign rd_data = mem[rd_ptr];
        end else begin : g_std
            // Registered read port loads the head entry on an accepted read.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    rd_data <= '0;
                end else if (clear) begin
                    rd_data <= '0;
                end else if (rd_vld) begin
                    rd_data <= mem[rd_ptr];
                end
            end
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_prog.sv
// Bench for sync_fifo_prog: a 16-deep standard-read instance and a 12-deep
// FWFT instance share one stimulus stream; each is checked every cycle
// against a queue-based model, plus directed literal expectations.
module tb_sync_fifo_prog;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       wr_en = 1'b0;
    logic       rd_en = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic [4:0] afa = 5'd15;
    logic [4:0] aea = 5'd2;
    logic [3:0] afb = 4'd11;
    logic [3:0] aeb = 4'd2;

    logic [7:0] rd_data_a, rd_data_b;
    logic       full_a, empty_a, afull_a, aempty_a, ov_a, un_a;
    logic       full_b, empty_b, afull_b, aempty_b, ov_b, un_b;
    logic [4:0] cnt_a;
    logic [3:0] cnt_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit run   = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_prog #(.DATA_WIDTH(8), .FIFO_DEPTH(16), .FWFT(1'b0)) dut_a (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data_a), .afull_thr(afa), .aempty_thr(aea),
        .full(full_a), .empty(empty_a), .afull(afull_a), .aempty(aempty_a),
        .fifo_cnt(cnt_a), .overflow(ov_a), .underflow(un_a)
    );

    sync_fifo_prog #(.DATA_WIDTH(8), .FIFO_DEPTH(12), .FWFT(1'b1)) dut_b (
        .clk(clk), .rst_n(rst_n), .clear(clear), .wr_en(wr_en), .wr_data(wr_data),
        .rd_en(rd_en), .rd_data(rd_data_b), .afull_thr(afb), .aempty_thr(aeb),
        .full(full_b), .empty(empty_b), .afull(afull_b), .aempty(aempty_b),
        .fifo_cnt(cnt_b), .overflow(ov_b), .underflow(un_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a queue per FIFO, updated from the request rules.
    logic [7:0] qa[$];
    logic [7:0] qb[$];
    bit         m_ov_a = 0, m_un_a = 0, m_ov_b = 0, m_un_b = 0;
    logic [7:0] m_rd_a = 8'h00;

    always @(posedge clk or negedge rst_n) begin
        bit fa, ea, fb, eb;
        if (!rst_n) begin
            qa.delete(); qb.delete();
            m_ov_a = 0; m_un_a = 0; m_ov_b = 0; m_un_b = 0; m_rd_a = 8'h00;
        end else if (clear) begin
            qa.delete(); qb.delete();
            m_ov_a = 0; m_un_a = 0; m_ov_b = 0; m_un_b = 0; m_rd_a = 8'h00;
        end else begin
            fa = (qa.size() == 16); ea = (qa.size() == 0);
            fb = (qb.size() == 12); eb = (qb.size() == 0);
            if (wr_en && fa) m_ov_a = 1;
            if (rd_en && ea) m_un_a = 1;
            if (wr_en && fb) m_ov_b = 1;
            if (rd_en && eb) m_un_b = 1;
            if (rd_en && !ea) m_rd_a = qa.pop_front();
            if (rd_en && !eb) void'(qb.pop_front());
            if (wr_en && !fa) qa.push_back(wr_data);
            if (wr_en && !fb) qb.push_back(wr_data);
        end
    end

    // Every-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (run) begin
            check("a_cnt",    32'(cnt_a),    32'(qa.size()));
            check("a_full",   32'(full_a),   32'(qa.size() == 16));
            check("a_empty",  32'(empty_a),  32'(qa.size() == 0));
            check("a_afull",  32'(afull_a),  32'(qa.size() >= int'(afa)));
            check("a_aempty", 32'(aempty_a), 32'(qa.size() <= int'(aea)));
            check("a_ovf",    32'(ov_a),     32'(m_ov_a));
            check("a_unf",    32'(un_a),     32'(m_un_a));
            check("a_rdata",  32'(rd_data_a), 32'(m_rd_a));
            check("b_cnt",    32'(cnt_b),    32'(qb.size()));
            check("b_full",   32'(full_b),   32'(qb.size() == 12));
            check("b_empty",  32'(empty_b),  32'(qb.size() == 0));
            check("b_afull",  32'(afull_b),  32'(qb.size() >= int'(afb)));
            check("b_aempty", 32'(aempty_b), 32'(qb.size() <= int'(aeb)));
            check("b_ovf",    32'(ov_b),     32'(m_ov_b));
            check("b_unf",    32'(un_b),     32'(m_un_b));
            if (qb.size() > 0) check("b_rdata", 32'(rd_data_b), 32'(qb[0]));
        end
    end

    // One clock of requests; returns 1ns after the edge that consumed them.
    task automatic step(input logic w, input logic r, input logic [7:0] d, input logic c);
        wr_en = w; rd_en = r; wr_data = d; clear = c;
        @(posedge clk); #1;
        wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    endtask

    initial begin
        int bias;
        int nw;
        int sz;
        logic [1:0] wr_rd;
        logic [7:0] wv;

        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;
        run   = 1'b1;

        // Reset state
        check("rst_cnt", 32'(cnt_a), 0);
        check("rst_empty", 32'(empty_a), 1);
        check("rst_full", 32'(full_a), 0);
        check("rst_aempty", 32'(aempty_a), 1);
        check("rst_afull", 32'(afull_a), 0);
        check("rst_ovf", 32'(ov_a), 0);
        check("rst_unf", 32'(un_a), 0);
        check("rst_rdata", 32'(rd_data_a), 0);

        // Underflow from empty, sticky until clear
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("unf_set", 32'(un_a), 1);
        check("unf_cnt", 32'(cnt_a), 0);
        check("unf_rdata", 32'(rd_data_a), 0);
        step(1'b0, 1'b0, 8'h00, 1'b0);
        check("unf_sticky", 32'(un_a), 1);
        step(1'b0, 1'b0, 8'h00, 1'b1);
        check("unf_clear", 32'(un_a), 0);

        // Fill and overflow
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 1'b0, 8'(i), 1'b0);
            if (i == 13) check("fill_afull14", 32'(afull_a), 0);
            if (i == 14) begin
                check("fill_afull15", 32'(afull_a), 1);
                check("fill_full15", 32'(full_a), 0);
            end
        end
        check("fill_full16", 32'(full_a), 1);
        check("fill_cnt16", 32'(cnt_a), 16);
        step(1'b1, 1'b0, 8'd16, 1'b0);
        check("ovf_cnt", 32'(cnt_a), 16);
        check("ovf_set", 32'(ov_a), 1);
        for (int i = 0; i < 16; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            check("drain_data", 32'(rd_data_a), 32'(i));
        end
        check("drain_empty", 32'(empty_a), 1);

        // Simultaneous read/write at empty
        step(1'b1, 1'b1, 8'h33, 1'b0);
        check("rw_empty_cnt", 32'(cnt_a), 1);
        check("rw_empty_unf", 32'(un_a), 1);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("rw_empty_data", 32'(rd_data_a), 32'h33);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous read/write at full
        for (int i = 0; i < 16; i++) step(1'b1, 1'b0, 8'(100 + i), 1'b0);
        step(1'b1, 1'b1, 8'd200, 1'b0);
        check("rw_full_cnt", 32'(cnt_a), 15);
        check("rw_full_ovf", 32'(ov_a), 1);
        check("rw_full_data", 32'(rd_data_a), 100);
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // Simultaneous read/write mid-occupancy preserves order
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 8'(50 + i), 1'b0);
        step(1'b1, 1'b1, 8'd55, 1'b0);
        check("rw_mid_cnt", 32'(cnt_a), 5);
        check("rw_mid_data", 32'(rd_data_a), 50);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, 8'h00, 1'b0);
            check("rw_mid_order", 32'(rd_data_a), 32'(51 + i));
        end
        step(1'b0, 1'b0, 8'h00, 1'b1);

        // FWFT latency on the 12-deep instance
        step(1'b1, 1'b0, 8'hA5, 1'b0);
        check("fwft_empty", 32'(empty_b), 0);
        check("fwft_data", 32'(rd_data_b), 32'hA5);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        check("fwft_pop_empty", 32'(empty_b), 1);

        // Clear at count 9 with a concurrent write
        step(1'b0, 1'b1, 8'h00, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b1, 1'b0, 8'(i + 7), 1'b0);
        check("clr_pre_cnt", 32'(cnt_a), 9);
        check("clr_pre_unf", 32'(un_a), 1);
        step(1'b1, 1'b0, 8'hEE, 1'b1);
        check("clr_cnt", 32'(cnt_a), 0);
        check("clr_empty", 32'(empty_a), 1);
        check("clr_ovf", 32'(ov_a), 0);
        check("clr_unf", 32'(un_a), 0);

        // Threshold changes act within the cycle
        step(1'b1, 1'b0, 8'h07, 1'b0);
        check("thr_aempty_2", 32'(aempty_a), 1);
        aea = 5'd0; #1;
        check("thr_aempty_0", 32'(aempty_a), 0);
        afa = 5'd0; #1;
        check("thr_afull_0", 32'(afull_a), 1);
        afa = 5'd17; #1;
        check("thr_afull_17", 32'(afull_a), 0);
        aea = 5'd16; #1;
        check("thr_aempty_16", 32'(aempty_a), 1);
        afa = 5'd15; aea = 5'd2;

        // Randomised traffic with drifting bias and thresholds
        for (int blk = 0; blk < 8; blk++) begin
            bias = (blk % 2 == 0) ? 3 : 1;
            for (int k = 0; k < 80; k++) begin
                if (k % 16 == 0) begin
                    afa = 5'($urandom_range(0, 18));
                    aea = 5'($urandom_range(0, 18));
                    afb = 4'($urandom_range(0, 15));
                    aeb = 4'($urandom_range(0, 15));
                end
                step(($urandom_range(0, 3) < 32'(bias)), ($urandom_range(0, 3) >= 32'(bias)),
                     8'($urandom), ($urandom_range(0, 99) == 0));
            end
        end
        afa = 5'd15; aea = 5'd2; afb = 4'd11; aeb = 4'd2;

        // Wrap the 12-deep instance several times at high occupancy
        step(1'b0, 1'b0, 8'h00, 1'b1);
        wv = 8'd0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'b0, wv, 1'b0);
            wv = wv + 8'd1;
        end
        nw = 0;
        for (int k = 0; k < 400 && nw < 40; k++) begin
            sz = qb.size();
            if (sz <= 8)       wr_rd = 2'b10;
            else if (sz >= 12) wr_rd = 2'b01;
            else               wr_rd = 2'($urandom_range(1, 3));
            step(wr_rd[1], wr_rd[0], wv, 1'b0);
            if (wr_rd[1]) begin
                wv = wv + 8'd1;
                nw++;
            end
        end
        for (int i = 0; i < 12; i++) step(1'b0, 1'b1, 8'h00, 1'b0);

        // Asynchronous reset mid-operation
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'(i + 1), 1'b0);
        step(1'b0, 1'b1, 8'h00, 1'b0);
        rst_n = 1'b0; #1;
        check("arst_cnt_a", 32'(cnt_a), 0);
        check("arst_empty_a", 32'(empty_a), 1);
        check("arst_rdata_a", 32'(rd_data_a), 0);
        check("arst_cnt_b", 32'(cnt_b), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(1'b1, 1'b0, 8'h5A, 1'b0);
        check("post_rst_cnt", 32'(cnt_a), 1);
        step(1'b0, 1'b0, 8'h00, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_prog.md
# sync_fifo_prog

Single-clock FIFO that succeeds our dual-clock FIFO for paths where producer and consumer share one clock. Adds any depth ≥ 2 (power of two not required) and a compile-time first-word-fall-through (FWFT) mode. Also adds run-time programmable almost-full/almost-empty thresholds, an occupancy count, a synchronous flush, and sticky overflow/underflow error flags. Used as the standard buffering stage between pipelined datapath blocks.

## Interface
- DATA_WIDTH, 8, width of each entry
- FIFO_DEPTH, 16, number of entries; any integer ≥ 2
- FWFT, 0, 0 = standard read (registered data, 1-cycle latency); 1 = first-word-fall-through
- CNT_WIDTH, $clog2(FIFO_DEPTH+1), width of count and threshold ports (derived; do not override)

Ports:
- clk  in  1  clock; all logic on rising edge
- rst_n  in  1  reset; one clock, asynchronous assert, active-low
- clear  in  1  synchronous flush
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data
- rd_en  in  1  read request (acknowledge of head entry in FWFT mode)
- rd_data  out  DATA_WIDTH  read data
- afull_thr  in  CNT_WIDTH  almost-full threshold
- aempty_thr  in  CNT_WIDTH  almost-empty threshold
- full  out  1  count == FIFO_DEPTH
- empty  out  1  count == 0
- afull  out  1  count ≥ afull_thr
- aempty  out  1  count ≤ aempty_thr
- fifo_cnt  out  CNT_WIDTH  current occupancy
- overflow  out  1  sticky: write attempted while full
- underflow  out  1  sticky: read attempted while empty

## Operation
- Storage is a FIFO_DEPTH-entry register array.
- Read and write pointers are $clog2(FIFO_DEPTH) bits wide. Each wraps from FIFO_DEPTH-1 to 0 by explicit compare, not by natural overflow.
- Occupancy is held in a registered counter; it is not derived from pointer difference.
- wr_vld = wr_en & ~full; rd_vld = rd_en & ~empty. Both evaluate against registered state at the start of the cycle.
- Counter update: +1 on wr_vld only; −1 on rd_vld only; unchanged on both or neither.
- Full with wr_en & rd_en: the read is accepted and the write is rejected; overflow is set. Count becomes FIFO_DEPTH−1.
- Empty with wr_en & rd_en: the write is accepted and the read is rejected; underflow is set. Count becomes 1.
- full, empty, afull and aempty are combinational compares of registered fifo_cnt. No pipeline delay beyond the counter.
- Threshold corner values:
  - afull_thr = 0: afull always 1.
  - afull_thr > FIFO_DEPTH: afull never 1.
  - aempty_thr ≥ FIFO_DEPTH: aempty always 1.
- Threshold ports may change at any time; flags track them combinationally.
- overflow is set on (wr_en & full); underflow is set on (rd_en & empty). Both stay set until clear or reset.
- clear has priority over wr_en and rd_en in the same cycle. On the next edge:
  - pointers and count go to 0;
  - overflow and underflow are cleared;
  - standard mode: rd_data goes to 0.
  - Array contents are not cleared.
- Standard mode (FWFT=0): rd_data is a register. It loads the head entry on the edge where rd_vld = 1 and holds otherwise.
- FWFT mode (FWFT=1):
  - rd_data = array[rd_ptr] combinationally and is valid whenever empty = 0.
  - rd_vld pops the head entry; the next entry is visible after that edge.
  - rd_data is don't-care while empty = 1.

## Timing
- Reset values: fifo_cnt 0, empty 1, full 0, aempty 1, afull 0 (given afull_thr ≥ 1), overflow 0, underflow 0, rd_data 0, pointers 0.
- Reset asserted mid-operation discards all contents immediately (asynchronous).
- Write latency: a write on edge N is reflected in fifo_cnt and flags after edge N.
  - FWFT: the word is on rd_data and empty = 0 in cycle N+1.
  - Standard: the first rd_en can be issued in cycle N+1, and data appears after that read edge.
- Read latency, standard mode: rd_en accepted at edge N gives data on rd_data in cycle N+1.
- Read latency, FWFT: 0 cycles; data is present before rd_en.
- Full-to-write: after a read at edge N, full drops in cycle N+1, and a write is accepted at edge N+1.
- Throughput is 1 write and 1 read per cycle sustained, at every occupancy from 1 to FIFO_DEPTH−1.

## Test plan
- **Fill and overflow** (DEPTH=16, afull_thr=15): 16 writes of 0..15 → afull at count 15, full at count 16. A 17th write gives count 16, overflow = 1, and data 16 is not stored. 16 reads return 0..15 in order.
- **Underflow** (FWFT=0): rd_en while empty after reset → underflow = 1, count stays 0, rd_data holds 0. Underflow stays set until clear pulses.
- **Simultaneous read/write**:
  - At count 5: count stays 5 and order is preserved.
  - At full: count goes to 15 and overflow = 1.
  - At empty: count goes to 1 and underflow = 1.
- **Non-power-of-two wrap** (DEPTH=12): 40 writes of an incrementing pattern interleaved with reads, holding count between 8 and 12 → the read sequence equals the write sequence and the pointers wrap 11→0 at least 3 times.
- **FWFT latency** (FWFT=1): a single write of 0xA5 at edge N → empty = 0 and rd_data = 0xA5 in cycle N+1. rd_en at edge N+1 → empty = 1 in cycle N+2.
- **Clear and thresholds**: clear asserted at count 9 together with wr_en → count 0 next cycle, empty = 1, both sticky flags 0. Changing aempty_thr from 2 to 0 at count 1 → aempty drops in the same cycle.
